// File: rtl/amoa_8x8p2_rt8_apx2.sv
// Purpose : approximate 8-operand adder; eight unsigned 8-bit operands -> 11-bit sum.
//           Upper 6 bits of each operand are summed exactly; the low 2 bits are
//           combined by a carry-free OR that never carries into the upper part.
// Latency : 2 clk cycles (operands sampled on edge N appear on summ after edge N+1).
// Backpressure: none; one result per cycle, no valid/ready.
// Option  : define AMOA_EXACT_EN to add the low 2-bit columns exactly, which makes
//           summ the true sum of all eight operands (max 2040).
// Ports   : clk      rising-edge clock
//           rst_n    asynchronous reset, active-high despite the name (1 = in reset)
//           x0..x7   unsigned 8-bit operands, sampled every edge
//           summ     registered 11-bit sum
//           stall    high until the pipeline holds a result from post-reset inputs
module amoa_8x8p2_rt8_apx2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  x0,
  input  logic [7:0]  x1,
  input  logic [7:0]  x2,
  input  logic [7:0]  x3,
  input  logic [7:0]  x4,
  input  logic [7:0]  x5,
  input  logic [7:0]  x6,
  input  logic [7:0]  x7,
  output logic [10:0] summ,
  output logic        stall
);

  // Stage 1: two 4-operand partial sums of the upper 6-bit fields (max 252 each).
  logic [7:0] w_s0;
  logic [7:0] w_s1;

  assign w_s0 = {2'b00, x0[7:2]} + {2'b00, x1[7:2]} + {2'b00, x2[7:2]} + {2'b00, x3[7:2]};
  assign w_s1 = {2'b00, x4[7:2]} + {2'b00, x5[7:2]} + {2'b00, x6[7:2]} + {2'b00, x7[7:2]};

  logic [7:0]  r_s0;
  logic [7:0]  r_s1;
  logic [1:0]  r_fill;
  logic [8:0]  w_hi;

  assign w_hi = {1'b0, r_s0} + {1'b0, r_s1};

`ifdef AMOA_EXACT_EN
  // Exact low columns: sum of eight 2-bit fields (max 24); the carries out of
  // this column are folded in at stage 2.
  logic [4:0] w_lo;
  logic [4:0] r_lo;

  assign w_lo = {3'b000, x0[1:0]} + {3'b000, x1[1:0]} + {3'b000, x2[1:0]} + {3'b000, x3[1:0]}
              + {3'b000, x4[1:0]} + {3'b000, x5[1:0]} + {3'b000, x6[1:0]} + {3'b000, x7[1:0]};
`else
  // Approximate low columns: bitwise OR, so the result never exceeds the exact sum.
  logic [1:0] w_lo;
  logic [1:0] r_lo;

  assign w_lo = x0[1:0] | x1[1:0] | x2[1:0] | x3[1:0]
              | x4[1:0] | x5[1:0] | x6[1:0] | x7[1:0];
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_s0 <= '0;
      r_s1 <= '0;
      r_lo <= '0;
    end else begin
      r_s0 <= w_s0;
      r_s1 <= w_s1;
      r_lo <= w_lo;
    end
  end

  // Stage 2: combine the partial sums with the low-column result.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      summ <= '0;
    end else begin
`ifdef AMOA_EXACT_EN
      summ <= {w_hi, 2'b00} + {6'b000000, r_lo};
`else
      summ <= {w_hi, r_lo};
`endif
    end
  end

  // Fill counter: saturates at 2 once both pipeline stages carry post-reset data.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_fill <= 2'd0;
    end else if (r_fill != 2'd2) begin
      r_fill <= r_fill + 2'd1;
    end
  end

  assign stall = (r_fill != 2'd2);

endmodule

// File: tb/tb_amoa_8x8p2_rt8_apx2.sv
// Bench for amoa_8x8p2_rt8_apx2: directed steps plus a scoreboard queue of
// expected sums, popped when the corresponding result reaches summ.
module tb_amoa_8x8p2_rt8_apx2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  xv [8];
  logic [10:0] summ;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int edges_since_release = 0;
  logic [10:0] exp_q [$];

  amoa_8x8p2_rt8_apx2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x0    (xv[0]),
    .x1    (xv[1]),
    .x2    (xv[2]),
    .x3    (xv[3]),
    .x4    (xv[4]),
    .x5    (xv[5]),
    .x6    (xv[6]),
    .x7    (xv[7]),
    .summ  (summ),
    .stall (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written per operand: exact upper sum, OR (or exact) low bits.
  function automatic logic [10:0] golden(input logic [7:0] v [8]);
    int hi;
    int lo_or;
    int total;
    hi = 0;
    lo_or = 0;
    total = 0;
    for (int k = 0; k < 8; k++) begin
      hi    = hi + int'(v[k] >> 2);
      lo_or = lo_or | int'(v[k] & 8'h03);
      total = total + int'(v[k]);
    end
`ifdef AMOA_EXACT_EN
    return 11'(total);
`else
    return 11'(hi * 4 + lo_or);
`endif
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int k = 0; k < 8; k++) xv[k] = v;
  endtask

  // Advance one edge with the current inputs; expv is the sum these inputs must produce.
  task automatic step(input string tag, input logic [10:0] expv);
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    edges_since_release++;
    chk({tag, "_stall"}, {10'd0, stall}, (edges_since_release < 2) ? 11'd1 : 11'd0);
    if (exp_q.size() >= 2) begin
      chk(tag, summ, exp_q.pop_front());
    end else begin
      chk({tag, "_fill"}, summ, 11'd0);
    end
  endtask

  task automatic step_model(input string tag);
    logic [7:0] tmp [8];
    for (int k = 0; k < 8; k++) tmp[k] = xv[k];
    step(tag, golden(tmp));
  endtask

  initial begin
    logic [7:0] c;

    // Reset held with random operands.
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) xv[k] = 8'($urandom);
    #1;
    chk("rst_summ0", summ, 11'd0);
    chk("rst_stall0", {10'd0, stall}, 11'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_summ", summ, 11'd0);
      chk("rst_stall", {10'd0, stall}, 11'd1);
      for (int k = 0; k < 8; k++) xv[k] = 8'($urandom);
    end

    // Release with all operands 0x05.
    set_all(8'h05);
    rst_n = 1'b0;
    edges_since_release = 0;
`ifdef AMOA_EXACT_EN
    step("x05_a", 11'd40);
    step("x05_b", 11'd40);
`else
    step("x05_a", 11'd33);
    step("x05_b", 11'd33);
`endif

    // Maximum operands.
    set_all(8'hFF);
`ifdef AMOA_EXACT_EN
    step("max", 11'd2040);
`else
    step("max", 11'd2019);
`endif

    // Incrementing pattern, c=0 directed then full sweep against the model.
    xv[0] = 8'd1; xv[1] = 8'd2; xv[2] = 8'd3; xv[3] = 8'd4;
    xv[4] = 8'd4; xv[5] = 8'd3; xv[6] = 8'd2; xv[7] = 8'd1;
`ifdef AMOA_EXACT_EN
    step("inc_c0", 11'd20);
`else
    step("inc_c0", 11'd11);
`endif
    for (int i = 0; i < 256; i++) begin
      c = 8'(i);
      xv[0] = c + 8'd1; xv[1] = c + 8'd2; xv[2] = c + 8'd3; xv[3] = c + 8'd4;
      xv[4] = c + 8'd4; xv[5] = c + 8'd3; xv[6] = c + 8'd2; xv[7] = c + 8'd1;
      step_model("inc_sweep");
    end

    // Zero-error case and all-zero operands.
    set_all(8'h04);
    xv[0] = 8'h03;
    step("zero_err", 11'd31);
    set_all(8'h00);
    step("all_zero", 11'd0);

    // Back-to-back random streaming.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 8; k++) xv[k] = 8'($urandom);
      step_model("stream");
    end

    // Reset asserted mid-stream, away from a clock edge.
    #3;
    rst_n = 1'b1;
    #1;
    chk("midrst_summ", summ, 11'd0);
    chk("midrst_stall", {10'd0, stall}, 11'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_summ_edge", summ, 11'd0);
    chk("midrst_stall_edge", {10'd0, stall}, 11'd1);

    // Release again and confirm the refill sequence.
    rst_n = 1'b0;
    edges_since_release = 0;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 8; k++) xv[k] = 8'($urandom);
      step_model("refill");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
